// File: rtl/sm_traffic_counter.sv
// Per-window NA traffic counters with a valid/ready report stream.
// SM_TRAFFIC_CHECKSUM_EN appends an XOR checksum of data words to each report.
module sm_traffic_counter #(
  parameter int NUM_TDM_ENDPOINTS = 4,
  parameter int CNT_WIDTH         = 16,
  parameter int WINDOW_CYCLES     = 1000000,
  parameter int ENDP_WIDTH        =
    NUM_TDM_ENDPOINTS > 1 ? $clog2(NUM_TDM_ENDPOINTS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            enable,
  input  logic [31:0]           data,
  input  logic [ENDP_WIDTH-1:0] ep,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  output logic                  out_last,
  output logic                  report_lost
);

  localparam int N  = NUM_TDM_ENDPOINTS;
  localparam int NC = 2 + 2 * N;
`ifdef SM_TRAFFIC_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  localparam int NW = 3 + 2 * N + CK;
  localparam int PW = $clog2(NW);
  localparam int TW = $clog2(WINDOW_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CMAX = {CNT_WIDTH{1'b1}};

  typedef enum logic {IDLE, SEND} state_e;

  state_e                state_q, state_d;
  logic [TW-1:0]         tmr_q;
  logic [15:0]           win_q;
  logic                  lost_q;
  logic [PW-1:0]         ptr_q;
  logic [CNT_WIDTH-1:0]  cnt_q [NC];
  logic [CNT_WIDTH-1:0]  nxt   [NC];
  logic                  ev    [NC];
  logic [31:0]           sh_q  [NW];
  logic [31:0]           snap  [NW];
  logic                  term;
  logic                  last_w;

  assign term   = tmr_q == TW'(WINDOW_CYCLES - 1);
  assign last_w = ptr_q == PW'(NW - 1);

  // Counter layout: be_send, be_recv, tdm_send[N], tdm_recv[N]
  always_comb begin
    for (int k = 0; k < NC; k++) ev[k] = 1'b0;
    ev[0] = enable[0];
    ev[1] = enable[1];
    for (int i = 0; i < N; i++) begin
      ev[2 + i]     = enable[2] && (ep == ENDP_WIDTH'(i));
      ev[2 + N + i] = enable[3] && (ep == ENDP_WIDTH'(i));
    end
  end

  always_comb begin
    for (int k = 0; k < NC; k++) begin
      nxt[k] = cnt_q[k];
      if (ev[k] && cnt_q[k] != CMAX)
        nxt[k] = cnt_q[k] + CNT_WIDTH'(1);
    end
  end

`ifdef SM_TRAFFIC_CHECKSUM_EN
  logic [31:0] acc_q;
  logic [31:0] acc_nxt;

  assign acc_nxt = (|enable) ? (acc_q ^ data) : acc_q;

  always_ff @(posedge clk) begin
    if (rst)       acc_q <= '0;
    else if (term) acc_q <= '0;
    else           acc_q <= acc_nxt;
  end
`else
  logic unused_data;
  assign unused_data = ^data;
`endif

  always_comb begin
    for (int w = 0; w < NW; w++) snap[w] = '0;
    snap[0] = {8'hA5, 8'(N), win_q};
    for (int k = 0; k < NC; k++)
      snap[1 + k] = 32'(nxt[k]);
`ifdef SM_TRAFFIC_CHECKSUM_EN
    snap[NW - 1] = acc_nxt;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q  <= '0;
      win_q  <= '0;
      lost_q <= 1'b0;
      ptr_q  <= '0;
      for (int k = 0; k < NC; k++) cnt_q[k] <= '0;
      for (int w = 0; w < NW; w++) sh_q[w] <= '0;
    end else begin
      tmr_q <= term ? '0 : tmr_q + TW'(1);
      for (int k = 0; k < NC; k++)
        cnt_q[k] <= term ? '0 : nxt[k];
      if (term) begin
        win_q <= win_q + 16'd1;
        // A report still in flight keeps its data; this window is lost
        if (state_q == IDLE)
          for (int w = 0; w < NW; w++) sh_q[w] <= snap[w];
        else
          lost_q <= 1'b1;
      end
      if (state_q == SEND && out_ready)
        ptr_q <= last_w ? '0 : ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (term) state_d = SEND;
      SEND: if (out_ready && last_w) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    if (state_q == SEND) begin
      out_valid = 1'b1;
      out_data  = sh_q[ptr_q];
      out_last  = last_w;
    end
  end

  assign report_lost = lost_q;

endmodule

// File: tb/tb_sm_traffic_counter.sv
// Directed bench for sm_traffic_counter (N=3, 4-bit counters, 32-cycle window).
// Reports, saturation, terminal-cycle events, backpressure loss and reset abort.
module tb_sm_traffic_counter;

`ifdef SM_TRAFFIC_CHECKSUM_EN
  localparam int NW = 10;
`else
  localparam int NW = 9;
`endif

  logic        clk;
  logic        rst;
  logic [3:0]  enable;
  logic [31:0] data;
  logic [1:0]  ep;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        report_lost;

  int n_chk;
  int n_pass;
  int t;

  logic [31:0] r0 [9];
  logic [31:0] r1 [9];
  logic [31:0] r2 [9];
  logic [31:0] r4 [9];

  sm_traffic_counter #(
    .NUM_TDM_ENDPOINTS(3),
    .CNT_WIDTH(4),
    .WINDOW_CYCLES(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .data(data),
    .ep(ep),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .report_lost(report_lost)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic step(input logic [3:0] e, input logic [1:0] p,
                      input logic [31:0] d);
    enable = e;
    ep     = p;
    data   = d;
    @(posedge clk);
    #1;
    enable = '0;
    ep     = '0;
    data   = '0;
    t = (t == 31) ? 0 : t + 1;
  endtask

  task automatic idle_until(input int n);
    while (t != n) step(4'b0000, 2'd0, 32'h0);
  endtask

  task automatic read_report(input string tag, input logic [31:0] b [9],
                             input logic [31:0] cks,
                             input logic [3:0] e0, input logic [1:0] p0);
    logic [31:0] ew;
    for (int w = 0; w < NW; w++) begin
      ew = (w < 9) ? b[w] : cks;
      chk($sformatf("%s_valid%0d", tag, w), {31'b0, out_valid}, 32'd1);
      chk($sformatf("%s_data%0d", tag, w), out_data, ew);
      chk($sformatf("%s_last%0d", tag, w), {31'b0, out_last},
          {31'b0, w == NW - 1});
      step(w == 0 ? e0 : 4'b0000, w == 0 ? p0 : 2'd0, 32'h0);
    end
    chk($sformatf("%s_done", tag), {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    t = 0;
    rst = 1'b1;
    enable = '0;
    data = '0;
    ep = '0;
    out_ready = 1'b1;
    r0 = '{32'hA5030000, 1, 0, 0, 3, 0, 0, 0, 2};
    r1 = '{32'hA5030001, 0, 15, 1, 0, 0, 0, 0, 0};
    r2 = '{32'hA5030002, 1, 1, 1, 0, 0, 0, 0, 0};
    r4 = '{32'hA5030004, 0, 0, 0, 0, 0, 1, 0, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_last", {31'b0, out_last}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_lost", {31'b0, report_lost}, 32'd0);
    rst = 1'b0;
    t = 0;

    // Window 0: mixed traffic
    step(4'b0100, 2'd1, 32'h0000FFFF);
    step(4'b0100, 2'd1, 32'hFFFF0000);
    step(4'b0100, 2'd1, 32'h0);
    step(4'b1000, 2'd2, 32'h0);
    step(4'b1000, 2'd2, 32'h0);
    step(4'b0001, 2'd0, 32'h0);
    idle_until(31);
    chk("pre_term_valid", {31'b0, out_valid}, 32'd0);
    step(4'b0000, 2'd0, 32'h0);
    read_report("rep0", r0, 32'hFFFFFFFF, 4'b0000, 2'd0);

    // Window 1: saturation, then a terminal-cycle event
    repeat (20) step(4'b0010, 2'd0, 32'h0);
    idle_until(31);
    step(4'b0100, 2'd0, 32'h0);
    read_report("rep1", r1, 32'h0, 4'b0100, 2'd0);

    // Window 2: out-of-range endpoint
    step(4'b1100, 2'd3, 32'h0F0F0000);
    step(4'b1100, 2'd3, 32'h0);
    step(4'b1111, 2'd3, 32'h12345678);
    idle_until(31);
    step(4'b0000, 2'd0, 32'h0);

    // Window 3: stalled consumer across a window end
    out_ready = 1'b0;
    step(4'b0001, 2'd0, 32'h0);
    step(4'b0001, 2'd0, 32'h0);
    chk("stall_valid", {31'b0, out_valid}, 32'd1);
    chk("stall_data", out_data, 32'hA5030002);
    idle_until(31);
    chk("stall_lost0", {31'b0, report_lost}, 32'd0);
    step(4'b0000, 2'd0, 32'h0);
    chk("stall_lost1", {31'b0, report_lost}, 32'd1);
    chk("stall_data2", out_data, 32'hA5030002);
    chk("stall_last", {31'b0, out_last}, 32'd0);
    out_ready = 1'b1;
    read_report("rep2", r2, 32'h1D3B5678, 4'b0000, 2'd0);
    chk("lost_sticky", {31'b0, report_lost}, 32'd1);

    // Window 4: report after a gap, aborted by reset
    step(4'b1000, 2'd0, 32'h0);
    idle_until(31);
    step(4'b0000, 2'd0, 32'h0);
    for (int w = 0; w < 3; w++) begin
      chk($sformatf("rep4_data%0d", w), out_data, r4[w]);
      step(4'b0000, 2'd0, 32'h0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_last", {31'b0, out_last}, 32'd0);
    chk("abort_data", out_data, 32'd0);
    chk("abort_lost", {31'b0, report_lost}, 32'd0);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
